vip_luma_gain_ctrl: RTL and testbench



---
 rtl/vip_luma_gain_ctrl.sv | 167 ++++++++++++++++
 tb/tb_vip_luma_gain_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vip_luma_gain_ctrl.sv
// Frame-level auto-brightness controller: accumulates luma per frame, divides for the mean and
// steps a signed Y offset toward a target. Optional IIR smoothing of the mean: VIP_LUMA_IIR_EN.
module vip_luma_gain_ctrl #(
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned MAX_OFS  = 64,
  parameter int unsigned DEADBAND = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_vsync,
  input  logic       frame_clken,
  input  logic [7:0] frame_Y,
  input  logic       cfg_enable,
  input  logic [7:0] cfg_target,
  input  logic [3:0] cfg_step,
  output logic [7:0] Y_up,
  output logic [7:0] Y_down,
  output logic [7:0] frame_mean,
  output logic       frame_done,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DcW = $clog2(ACC_W);

  typedef enum logic [1:0] {StIdle, StAcc, StDiv, StUpd} state_e;

  state_e             state_q, state_d;
  logic               vsync_d, fall_q;
  logic               rise, fall;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   rem_q, quo_q;
  logic [DcW-1:0]     div_cnt_q;
  logic signed [9:0]  ofs_q;

  logic [ACC_W:0]     acc_sum, shifted, trial;
  logic [7:0]         q_sat, mean_ctl;
  logic signed [8:0]  err;
  logic [8:0]         abs_err;
  logic signed [10:0] ofs_sum, ofs_d, ofs_neg, max_pos;

  assign rise = frame_vsync & ~vsync_d;
  assign fall = ~frame_vsync & vsync_d;
  assign busy = (state_q == StDiv) || (state_q == StUpd);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (rise) state_d = StAcc;
      // fall is acted on one cycle late so the divider loads from a settled accumulator
      StAcc:  if (fall_q) state_d = (cnt_q == '0) ? StIdle : StDiv;
      StDiv:  if (div_cnt_q == DcW'(ACC_W - 1)) state_d = StUpd;
      StUpd:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      vsync_d <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_d <= frame_vsync;
      fall_q  <= fall;
    end
  end

  assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(frame_Y);
  assign shifted = {rem_q, quo_q[ACC_W-1]};
  assign trial   = shifted - {1'b0, ACC_W'(cnt_q)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_cnt_q <= '0;
    end else begin
      if (state_q == StIdle && rise) begin
        acc_q <= frame_clken ? ACC_W'(frame_Y) : '0;
        cnt_q <= frame_clken ? CNT_W'(1) : '0;
      end else if (state_q == StAcc && frame_vsync && frame_clken) begin
        acc_q <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == StAcc && state_d == StDiv) begin
        quo_q     <= acc_q;
        rem_q     <= '0;
        div_cnt_q <= '0;
      end else if (state_q == StDiv) begin
        div_cnt_q <= div_cnt_q + DcW'(1);
        if (!trial[ACC_W]) begin
          rem_q <= trial[ACC_W-1:0];
          quo_q <= {quo_q[ACC_W-2:0], 1'b1};
        end else begin
          rem_q <= shifted[ACC_W-1:0];
          quo_q <= {quo_q[ACC_W-2:0], 1'b0};
        end
      end
    end
  end

  assign q_sat = (|quo_q[ACC_W-1:8]) ? 8'hFF : quo_q[7:0];

`ifdef VIP_LUMA_IIR_EN
  logic [7:0] ms_q;
  logic       seeded_q;
  logic [9:0] ms_sum;

  assign ms_sum   = {2'b00, ms_q} + {1'b0, ms_q, 1'b0} + {2'b00, q_sat};
  assign mean_ctl = seeded_q ? ms_sum[9:2] : q_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_q     <= '0;
      seeded_q <= 1'b0;
    end else if (state_q == StUpd) begin
      ms_q     <= mean_ctl;
      seeded_q <= 1'b1;
    end
  end
`else
  assign mean_ctl = q_sat;
`endif

  assign max_pos = 11'(MAX_OFS);

  always_comb begin
    err     = $signed({1'b0, mean_ctl}) - $signed({1'b0, cfg_target});
    abs_err = err[8] ? 9'(-err) : 9'(err);
    ofs_sum = 11'(ofs_q);
    if (err[8]) ofs_sum = 11'(ofs_q) + $signed({7'b0, cfg_step});
    else        ofs_sum = 11'(ofs_q) - $signed({7'b0, cfg_step});
    if (ofs_sum > max_pos)       ofs_sum = max_pos;
    else if (ofs_sum < -max_pos) ofs_sum = -max_pos;
    ofs_d = 11'(ofs_q);
    if (!cfg_enable)                  ofs_d = '0;
    else if (32'(abs_err) > DEADBAND) ofs_d = ofs_sum;
    ofs_neg = -ofs_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ofs_q      <= '0;
      Y_up       <= '0;
      Y_down     <= '0;
      frame_mean <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= (state_q == StUpd);
      if (state_q == StUpd) begin
        frame_mean <= mean_ctl;
        ofs_q      <= ofs_d[9:0];
        Y_up       <= (ofs_d > 0) ? ofs_d[7:0] : 8'd0;
        Y_down     <= (ofs_d < 0) ? ofs_neg[7:0] : 8'd0;
      end
      if (rise && busy) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vip_luma_gain_ctrl.sv
// Scoreboard bench for vip_luma_gain_ctrl: frame-level reference model feeds an expectation
// queue; a monitor checks every frame_done pulse against it.
module tb_vip_luma_gain_ctrl;
  localparam int ACC_W    = 32;
  localparam int MAX_OFS  = 64;
  localparam int DEADBAND = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_vsync = 1'b0;
  logic       frame_clken = 1'b0;
  logic [7:0] frame_Y = '0;
  logic       cfg_enable = 1'b1;
  logic [7:0] cfg_target = 8'd128;
  logic [3:0] cfg_step = 4'd4;
  logic [7:0] Y_up, Y_down, frame_mean;
  logic       frame_done, overrun, busy;

  vip_luma_gain_ctrl #(
    .ACC_W(ACC_W), .CNT_W(24), .MAX_OFS(MAX_OFS), .DEADBAND(DEADBAND)
  ) dut (
    .clk(clk), .rst(rst), .frame_vsync(frame_vsync), .frame_clken(frame_clken),
    .frame_Y(frame_Y), .cfg_enable(cfg_enable), .cfg_target(cfg_target), .cfg_step(cfg_step),
    .Y_up(Y_up), .Y_down(Y_down), .frame_mean(frame_mean), .frame_done(frame_done),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     mean;
    int     up;
    int     down;
    longint due;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  int ofs_m = 0;
  int ms_m = 0;
  bit seeded_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int up_m();
    return (ofs_m > 0) ? ofs_m : 0;
  endfunction

  function automatic int down_m();
    return (ofs_m < 0) ? -ofs_m : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_frame(input int sum, input int cnt, input longint due);
    int q, m, err;
    exp_t e;
    q = sum / cnt;
    if (q > 255) q = 255;
`ifdef VIP_LUMA_IIR_EN
    if (seeded_m) ms_m = (3 * ms_m + q) / 4;
    else ms_m = q;
    seeded_m = 1;
    m = ms_m;
`else
    m = q;
`endif
    err = m - int'(cfg_target);
    if (!cfg_enable) ofs_m = 0;
    else if (err > DEADBAND || err < -DEADBAND) begin
      if (err < 0) ofs_m = ofs_m + int'(cfg_step);
      else ofs_m = ofs_m - int'(cfg_step);
      if (ofs_m > MAX_OFS) ofs_m = MAX_OFS;
      if (ofs_m < -MAX_OFS) ofs_m = -MAX_OFS;
    end
    e.mean = m;
    e.up = up_m();
    e.down = down_m();
    e.due = due;
    exp_q.push_back(e);
  endtask

  // Drives one frame starting at the current cycle; the first pixel lands on the rise cycle.
  task automatic send_frame(input int n, input int base, input int jit, input bit gaps,
                            input bit expect_update);
    int sum, y;
    sum = 0;
    frame_vsync = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        frame_clken = 1'b0;
        step();
      end
      y = base + int'($urandom_range(0, 2 * jit)) - jit;
      if (y < 0) y = 0;
      if (y > 255) y = 255;
      frame_clken = 1'b1;
      frame_Y = 8'(y);
      sum += y;
      step();
    end
    frame_clken = 1'b0;
    frame_vsync = 1'b0;
    if (expect_update) model_frame(sum, n, cyc + ACC_W + 3);
  endtask

  task automatic gap();
    repeat (ACC_W + 8) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && frame_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame_done", 32'(frame_done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("frame_mean", 32'(frame_mean), 32'(e.mean));
        check("Y_up", 32'(Y_up), 32'(e.up));
        check("Y_down", 32'(Y_down), 32'(e.down));
        check("done_latency", 32'(cyc), 32'(e.due));
        check("up_down_exclusive", 32'((Y_up != 0) && (Y_down != 0)), 32'd0);
      end
    end
  end

  initial begin
    repeat (3) step();
    check("rst_Y_up", 32'(Y_up), 32'd0);
    check("rst_Y_down", 32'(Y_down), 32'd0);
    check("rst_mean", 32'(frame_mean), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    send_frame(16, 100, 0, 0, 1);
    gap();
    check("first_frame_up", 32'(Y_up), 32'd4);
    check("first_frame_mean", 32'(frame_mean), 32'd100);

    for (int f = 0; f < 20; f++) begin
      send_frame(16, 50, 0, f[0], 1);
      gap();
    end
    check("dark_clamp_up", 32'(Y_up), 32'(MAX_OFS));
    for (int f = 0; f < 20; f++) begin
      send_frame(16, 220, 0, 0, 1);
      gap();
    end
    check("bright_down", 32'(Y_down), 32'(down_m()));

    send_frame(12, 127, 0, 0, 1);
    gap();
    send_frame(12, 130, 0, 1, 1);
    gap();
    cfg_enable = 1'b0;
    send_frame(12, 130, 0, 0, 1);
    gap();
    check("disabled_up", 32'(Y_up), 32'd0);
    check("disabled_down", 32'(Y_down), 32'd0);
    cfg_enable = 1'b1;
    send_frame(10, 30, 0, 0, 1);
    gap();

    frame_vsync = 1'b1;
    repeat (6) step();
    frame_vsync = 1'b0;
    gap();
    check("empty_frame_up", 32'(Y_up), 32'(up_m()));
    check("empty_frame_busy", 32'(busy), 32'd0);

    check("overrun_before", 32'(overrun), 32'd0);
    send_frame(16, 60, 4, 0, 1);
    repeat (5) step();
    send_frame(10, 250, 0, 0, 0);
    gap();
    check("overrun_set", 32'(overrun), 32'd1);
    send_frame(16, 60, 4, 1, 1);
    gap();
    check("overrun_sticky", 32'(overrun), 32'd1);

    send_frame(16, 20, 0, 0, 1);
    repeat (10) step();
    check("busy_in_div", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("middiv_rst_up", 32'(Y_up), 32'd0);
    check("middiv_rst_down", 32'(Y_down), 32'd0);
    check("middiv_rst_mean", 32'(frame_mean), 32'd0);
    check("middiv_rst_overrun", 32'(overrun), 32'd0);
    check("middiv_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    ofs_m = 0;
    ms_m = 0;
    seeded_m = 0;
    step();
    rst = 1'b0;
    repeat (2) step();

    send_frame(8, 100, 0, 0, 1);
    gap();
    send_frame(8, 200, 0, 0, 1);
    gap();

    for (int f = 0; f < 30; f++) begin
      cfg_target = 8'($urandom_range(0, 255));
      cfg_step = 4'($urandom_range(0, 15));
      cfg_enable = ($urandom_range(0, 7) != 0);
      send_frame(int'($urandom_range(1, 40)), int'($urandom_range(0, 255)), 8, 1, 1);
      gap();
    end

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
